// File: rtl/hazard_unit_sb_if.sv
// Hazard unit pipeline bundle: D/E/M/W register tags in, stall/flush/forward out.
// master = pipeline side, slave = hazard unit side.
interface hazard_unit_sb_if #(
  parameter int AW = 5
);
  logic [AW-1:0] A0D;
  logic [AW-1:0] A1D;
  logic [AW-1:0] A2D;
  logic          RWD;
  logic          LOD;
  logic [AW-1:0] A0E;
  logic [AW-1:0] A1E;
  logic [AW-1:0] A2E;
  logic          MDE0;
  logic          LOE;
  logic          PCSE;
  logic [AW-1:0] A2M;
  logic          RWM;
  logic [AW-1:0] A2W;
  logic          RWW;
  logic [1:0]    forward_op1E;
  logic [1:0]    forward_op2E;
  logic          stallF;
  logic          stallD;
  logic          flushD;
  logic          flushE;
  logic          long_busy;
  logic [AW-1:0] long_rd;
  logic          long_done;
  logic [31:0]   perf_stall_cnt;
  logic [31:0]   perf_flush_cnt;

  modport master (
    output A0D, A1D, A2D, RWD, LOD,
    output A0E, A1E, A2E, MDE0, LOE, PCSE,
    output A2M, RWM, A2W, RWW,
    input  forward_op1E, forward_op2E,
    input  stallF, stallD, flushD, flushE,
    input  long_busy, long_rd, long_done,
    input  perf_stall_cnt, perf_flush_cnt
  );

  modport slave (
    input  A0D, A1D, A2D, RWD, LOD,
    input  A0E, A1E, A2E, MDE0, LOE, PCSE,
    input  A2M, RWM, A2W, RWW,
    output forward_op1E, forward_op2E,
    output stallF, stallD, flushD, flushE,
    output long_busy, long_rd, long_done,
    output perf_stall_cnt, perf_flush_cnt
  );
endinterface

// File: rtl/hazard_unit_sb.sv
// 5-stage hazard unit with M/W forwarding, load-use stall, branch flush and a
// scoreboard for one iterative long-latency unit. Ports: clk, rst, hif (slave).
// Optional HAZ_PERF_EN builds stall/flush cycle counters.
module hazard_unit_sb #(
  parameter int AW       = 5,
  parameter int LONG_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  hazard_unit_sb_if.slave hif
);
  localparam logic [7:0] CNT_INIT = 8'(LONG_LAT - 1);

  logic          busy;
  logic [AW-1:0] rd;
  logic [7:0]    cnt;
  logic          done;

  logic m0, w0, m1, w1;
  logic lu, li, sb, stall;

  // W hits are masked by M hits so the decoders stay one-hot
  always_comb begin
    m0 = hif.RWM && hif.A0E != '0 && hif.A0E == hif.A2M;
    m1 = hif.RWM && hif.A1E != '0 && hif.A1E == hif.A2M;
    w0 = !m0 && hif.RWW && hif.A0E != '0
         && hif.A0E == hif.A2W;
    w1 = !m1 && hif.RWW && hif.A1E != '0
         && hif.A1E == hif.A2W;
  end

  always_comb begin
    hif.forward_op1E = 2'b00;
    unique case (1'b1)
      m0:      hif.forward_op1E = 2'b10;
      w0:      hif.forward_op1E = 2'b01;
      default: hif.forward_op1E = 2'b00;
    endcase
  end

  always_comb begin
    hif.forward_op2E = 2'b00;
    unique case (1'b1)
      m1:      hif.forward_op2E = 2'b10;
      w1:      hif.forward_op2E = 2'b01;
      default: hif.forward_op2E = 2'b00;
    endcase
  end

  always_comb begin
    lu = hif.MDE0 && hif.A2E != '0
         && (hif.A0D == hif.A2E || hif.A1D == hif.A2E);
    li = hif.LOE && hif.A2E != '0
         && (hif.A0D == hif.A2E || hif.A1D == hif.A2E
             || (hif.RWD && hif.A2D == hif.A2E));
    // released in the done cycle: the regfile write-first port bypasses
    sb = busy && !done
         && (hif.LOD
             || (rd != '0
                 && (hif.A0D == rd || hif.A1D == rd
                     || (hif.RWD && hif.A2D == rd))));
    // a taken branch wins so fetch picks up the new target
    stall = (lu || li || sb) && !hif.PCSE;
  end

  assign hif.stallF = stall;
  assign hif.stallD = stall;
  assign hif.flushD = hif.PCSE;
  assign hif.flushE = stall || hif.PCSE;

  assign done          = busy && cnt == 8'd0;
  assign hif.long_busy = busy;
  assign hif.long_rd   = rd;
  assign hif.long_done = done;

  // issued op is older than any branch in E, so PCSE never cancels it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      rd   <= '0;
      cnt  <= 8'd0;
    end else if (hif.LOE && !busy) begin
      busy <= 1'b1;
      rd   <= hif.A2E;
      cnt  <= CNT_INIT;
    end else if (busy) begin
      if (cnt == 8'd0) busy <= 1'b0;
      else             cnt  <= cnt - 8'd1;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] st_cnt;
  logic [31:0] fl_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_cnt <= 32'd0;
      fl_cnt <= 32'd0;
    end else begin
      if (stall)    st_cnt <= st_cnt + 32'd1;
      if (hif.PCSE) fl_cnt <= fl_cnt + 32'd1;
    end
  end

  assign hif.perf_stall_cnt = st_cnt;
  assign hif.perf_flush_cnt = fl_cnt;
`else
  assign hif.perf_stall_cnt = 32'd0;
  assign hif.perf_flush_cnt = 32'd0;
`endif
endmodule

// File: doc/hazard_unit_sb.md
Name: hazard_unit_sb

Overview:
Scoreboarded successor to the 5-stage hazard unit. Keeps the existing M/W operand forwarding, load-use stall and branch flush. Adds a sequential scoreboard for one non-pipelined long-latency unit (iterative mul/div) that issues from E and writes the register file LONG_LAT cycles later through a dedicated write-first port. Generalised in address width and latency; x0 is filtered on every compare.

Parameters:
AW, 5, register address width
LONG_LAT, 4, long-unit latency in cycles from issue to writeback (legal range 2..255)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
A0D, A1D  in  AW  source regs of the instruction in D
A2D  in  AW  dest reg of the instruction in D
RWD  in  1  instruction in D writes a register
LOD  in  1  instruction in D is a long op
A0E, A1E, A2E  in  AW  sources/dest of the instruction in E
MDE0  in  1  instruction in E is a load
LOE  in  1  instruction in E is a long op
PCSE  in  1  branch/jump taken in E
A2M, RWM  in  AW,1  dest/write-enable in M
A2W, RWW  in  AW,1  dest/write-enable in W
forward_op1E, forward_op2E  out  2  00 regfile, 10 from M, 01 from W
stallF, stallD, flushD, flushE  out  1  pipeline controls
long_busy  out  1  long unit occupied
long_rd  out  AW  pending long-op destination
long_done  out  1  one-cycle long writeback strobe
perf_stall_cnt, perf_flush_cnt  out  32  stall and flush cycle counters (see Optional Feature)

Behaviour:
- Forwarding (comb): for each operand, M has priority over W. Select 10 if (AxE==A2M && RWM && AxE!=0). Otherwise select 01 if the same test passes against A2W/RWW. Otherwise 00.
- Load-use: lu = MDE0 && A2E!=0 && (A0D==A2E || A1D==A2E).
- Long issue hazard: li = LOE && A2E!=0 && (A0D==A2E || A1D==A2E || (RWD && A2D==A2E)). Covers RAW and WAW.
- Scoreboard hazard: sb = long_busy && !long_done && (LOD || (long_rd!=0 && (A0D==long_rd || A1D==long_rd || (RWD && A2D==long_rd)))).
- stall = (lu | li | sb) && !PCSE. stallF = stallD = stall. flushE = stall | PCSE. flushD = PCSE. PCSE overrides stall so fetch takes the new target.
- Issue: at the clk edge where LOE && !long_busy: long_rd <= A2E, long_busy <= 1, cnt <= LONG_LAT-1. LOE while busy cannot occur because sb holds it in D.
- Counter: while busy, cnt decrements by 1 each cycle and saturates at 0. long_done = long_busy && cnt==0, decoded from registers with no input-to-output path. At the edge after long_done, long_busy <= 0.
- Timeline: issue edge ends cycle T. long_busy is high for T+1..T+LONG_LAT. long_done is high only in T+LONG_LAT. A reader in D is released in T+LONG_LAT via the write-first regfile.
- PCSE does not cancel an issued long op; it is older than the branch.
- Reset (async): long_busy=0, long_rd=0, cnt=0, long_done=0, perf counters=0. Comb outputs follow inputs. Reset mid-operation drops the pending op silently.

Optional Feature:
HAZ_PERF_EN. When defined: perf_stall_cnt increments on every cycle with stallD=1, and perf_flush_cnt increments on every cycle with flushD=1. Both wrap at 2^32 and clear on rst. When undefined: both ports are tied to 32'd0 and no counter flops are built.

Test Plan:
- Forwarding priority: A0E=5, A2M=5, RWM=1, A2W=5, RWW=1 -> forward_op1E=10. Set RWM=0 -> 01. Set A0E=0 -> 00.
- Load-use: MDE0=1, A2E=7, A1D=7 -> stallF=stallD=flushE=1, flushD=0. Set A2E=0 -> no stall.
- Long op, LONG_LAT=4: LOE=1, A2E=9 issued at T, then A0D=9 held in D -> stall in T (li) and T+1..T+3 (sb). Stall released in T+4 with long_done=1. long_busy=0 at T+5.
- WAW and structural: while busy with long_rd=9, D has RWD=1, A2D=9 -> stall. D has LOD=1 with unrelated regs -> stall until long_done.
- Branch priority: PCSE=1 together with a load-use match -> stallF=stallD=0, flushD=flushE=1. long_busy and cnt are unaffected.
- Async reset while long_busy=1, cnt=2 -> long_busy, long_done and long_rd are 0 immediately. No long_done pulse after release. With HAZ_PERF_EN, counters read 0.
